pwm_multi_ctrl: RTL

Parametrised multi-channel PWM controller with button-driven duty adjustment.
- Two debounced push-buttons step the duty of the channel picked by ch_sel, up or down by STEP, with saturation.
- All channels share one free-running period counter. Each channel's duty is double-buffered so a change only takes effect at a period boundary, giving glitch-free edges.
- Also produces the activity LEDs and a slow square-wave heartbeat, for the pin-limited top wrapper.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/btn_debounce.sv | 32 +++
 rtl/pwm_multi_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared saturation math and sizing helpers for the PWM controller
package pwm_pkg;
   function automatic int duty_max(input int w);
      return (1 << w) - 1;
   endfunction
   function automatic int sat_add(input int d, input int s, input int m);
      return (d + s > m) ? m : d + s;
   endfunction
   function automatic int sat_sub(input int d, input int s);
      return (d < s) ? 0 : d - s;
   endfunction
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-sample debouncer and rising-edge pulse
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync  <= '0;
         level <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync <= {sync[0], btn};
         rise <= 1'b0;
         if (sync[1] == level)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync[1];
            rise  <= sync[1];
         end else
            cnt <= cnt + CW'(1);
      end
endmodule

// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl: button-stepped multi-channel PWM with period-aligned duty, LEDs and heartbeat
module pwm_multi_ctrl
   import pwm_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int WIDTH           = 8,
   parameter int STEP            = 16,
   parameter int DEBOUNCE_CYCLES = 256,
   parameter int LED_HOLD        = 4096,
   parameter int CLK_HZ          = 12500
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_inc,
   input  logic                        btn_dec,
   input  logic [$clog2(CHANNELS)-1:0] ch_sel,
   output logic [CHANNELS-1:0]         pwm_out,
   output logic                        inc_led,
   output logic                        dec_led,
   output logic                        clock_1hz
);
   localparam int CW   = ch_w(CHANNELS);
   localparam int DMAX = duty_max(WIDTH);
   localparam int LW   = $clog2(LED_HOLD + 1);
   localparam int HW   = $clog2(CLK_HZ / 2 + 1);
   logic             inc_ev, dec_ev, sel_ok, inc_ok, dec_ok;
   logic [WIDTH-1:0] cnt;
   logic [LW-1:0]    inc_t, dec_t;
   logic [HW-1:0]    div;
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk(clk), .rst_n(rst_n), .btn(btn_inc), .rise(inc_ev)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
      .clk(clk), .rst_n(rst_n), .btn(btn_dec), .rise(dec_ev)
   );
   // simultaneous inc and dec cancel out, including the LED retrigger
   assign sel_ok = {1'b0, ch_sel} < (CW + 1)'(CHANNELS);
   assign inc_ok = inc_ev & ~dec_ev & sel_ok;
   assign dec_ok = dec_ev & ~inc_ev & sel_ok;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= '0;
      else
         cnt <= cnt + WIDTH'(1);
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] duty, shadow;
      logic             p;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            duty   <= '0;
            shadow <= '0;
            p      <= 1'b0;
         end else begin
            if (inc_ok && ch_sel == CW'(i))
               duty <= WIDTH'(sat_add(int'(duty), STEP, DMAX));
            else if (dec_ok && ch_sel == CW'(i))
               duty <= WIDTH'(sat_sub(int'(duty), STEP));
            if (cnt == '1)
               shadow <= duty;
            p <= (cnt < shadow) || (shadow == '1);
         end
      assign pwm_out[i] = p;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         inc_t     <= '0;
         dec_t     <= '0;
         inc_led   <= 1'b0;
         dec_led   <= 1'b0;
         div       <= '0;
         clock_1hz <= 1'b0;
      end else begin
         inc_t     <= inc_ok ? LW'(LED_HOLD) : inc_t - LW'(inc_t != '0);
         dec_t     <= dec_ok ? LW'(LED_HOLD) : dec_t - LW'(dec_t != '0);
         inc_led   <= inc_ok || inc_t > LW'(1);
         dec_led   <= dec_ok || dec_t > LW'(1);
         div       <= (div == HW'(CLK_HZ / 2 - 1)) ? '0 : div + HW'(1);
         clock_1hz <= clock_1hz ^ (div == HW'(CLK_HZ / 2 - 1));
      end
endmodule
